// File: rtl/pci_initiator_if.sv
// Shared initiator/target bus: request/grant, frame, handshake and address/data.
// All control lines are active-low; oe qualifies the initiator-driven signals.
interface pci_initiator_if;
  logic        req;
  logic        gnt;
  logic        frame;
  logic        irdy;
  logic        trdy;
  logic        oe;
  logic [31:0] ad;

  modport master (output req, frame, irdy, ad, oe, input gnt, trdy);
  modport slave  (input req, frame, irdy, ad, oe, output gnt, trdy);
endinterface

// File: rtl/pci_initiator.sv
// Bus-master initiator: buffers write data in a FIFO, then arbitrates for the bus and
// bursts it out with the irdy/trdy handshake, re-requesting on grant loss.
module pci_initiator #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wdata,
  input  logic             wvalid,
  output logic             wready,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  pci_initiator_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StReq, StAddr, StData, StTurn} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             req_q, req_d, frame_q, frame_d, irdy_q, irdy_d, oe_q, oe_d;
  logic [31:0]      ad_q, ad_d;
  logic             done_q, done_d, err_q, err_d;

  logic [31:0]      mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop, flush;

  assign wready    = (count_q != CntW'(DEPTH));
  assign push      = wvalid && wready && !flush;
  assign cmd_ready = (state_q == StIdle) && (32'(count_q) >= 32'(cmd_len));
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;
  assign bus.req   = req_q;
  assign bus.frame = frame_q;
  assign bus.irdy  = irdy_q;
  assign bus.oe    = oe_q;
  assign bus.ad    = ad_q;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    req_d   = 1'b1;
    frame_d = 1'b1;
    irdy_d  = 1'b1;
    oe_d    = 1'b0;
    ad_d    = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StReq;
            req_d   = 1'b0;
          end
        end
      end
      StReq: begin
        req_d = 1'b0;
        // Bus idle: frame and trdy both deasserted while we hold the grant.
        if (!bus.gnt && bus.frame && bus.trdy) begin
          state_d = StAddr;
          req_d   = 1'b1;
          oe_d    = 1'b1;
          frame_d = 1'b0;
          ad_d    = addr_q;
        end
      end
      StAddr: begin
        state_d = StData;
        oe_d    = 1'b1;
        irdy_d  = 1'b0;
        frame_d = (rem_q == LEN_W'(1));
        ad_d    = mem[rptr_q];
      end
      StData: begin
        oe_d   = 1'b1;
        irdy_d = 1'b0;
        if (!bus.trdy) begin
          pop    = 1'b1;
          addr_d = addr_q + 32'd4;
          rem_d  = rem_q - LEN_W'(1);
          wait_d = '0;
          if (rem_q == LEN_W'(1) || frame_q) begin
            state_d = StTurn;
            oe_d    = 1'b0;
            irdy_d  = 1'b1;
          end else begin
            frame_d = (rem_q == LEN_W'(2)) || bus.gnt;
            ad_d    = mem[rptr_q + PtrW'(1)];
          end
        end else begin
          wait_d  = wait_q + WaitW'(1);
          // A grant lost during a wait turns the pending phase into the final one.
          frame_d = frame_q || bus.gnt;
          ad_d    = ad_q;
          if (wait_q == WaitW'(TIMEOUT - 1)) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            irdy_d  = 1'b1;
            frame_d = 1'b1;
            ad_d    = '0;
            wait_d  = '0;
            err_d   = 1'b1;
            flush   = 1'b1;
          end
        end
      end
      StTurn: begin
        if (rem_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StReq;
          req_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      req_q   <= 1'b1;
      frame_q <= 1'b1;
      irdy_q  <= 1'b1;
      oe_q    <= 1'b0;
      ad_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      frame_q <= frame_d;
      irdy_q  <= irdy_d;
      oe_q    <= oe_d;
      ad_q    <= ad_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: acts as arbiter and target, records address and data
// phases per command and compares them with hand-computed expectations.
module tb_pci_initiator;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wdata;
  logic        wvalid, wready;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        busy, done, err;

  pci_initiator_if bus ();

  pci_initiator #(.DEPTH(8), .LEN_W(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic        got_frame[$];
  int          n_done, n_errp, n_req, n_wait;
  logic        fin, rel_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    wdata  = w;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  // Issue one command and play target: tmode 0 = trdy always, 1 = alternate, 2 = never.
  task automatic run_cmd(input logic [31:0] a, input logic [3:0] len, input int tmode,
                         input bit gloss);
    int dc;
    got_addr.delete();
    got_data.delete();
    got_frame.delete();
    n_done = 0; n_errp = 0; n_req = 0; n_wait = 0; dc = 0;
    fin = 1'b0; rel_ok = 1'b0;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (done) begin
        n_done++;
        fin = 1'b1;
      end
      if (err) begin
        n_errp++;
        fin = 1'b1;
        rel_ok = !bus.oe && bus.frame && bus.irdy;
      end
      if (!bus.req) n_req++;
      if (gloss && bus.gnt && !bus.req) bus.gnt = 1'b0;
      if (bus.oe && !bus.frame && bus.irdy) got_addr.push_back(bus.ad);
      if (!bus.irdy) begin
        case (tmode)
          0:       bus.trdy = 1'b0;
          1:       bus.trdy = (dc % 2) != 0;
          default: bus.trdy = 1'b1;
        endcase
        dc++;
        if (bus.trdy) begin
          n_wait++;
        end else begin
          got_data.push_back(bus.ad);
          got_frame.push_back(bus.frame);
          if (gloss && got_data.size() == 1) bus.gnt = 1'b1;
        end
      end else begin
        bus.trdy = 1'b1;
      end
    end
    check("cmd_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    rst = 1'b1; wdata = '0; wvalid = 1'b0; cmd_valid = 1'b0;
    cmd_addr = '0; cmd_len = 4'd1; bus.gnt = 1'b1; bus.trdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus.req), 32'd1);
    check("rst_frame", 32'(bus.frame), 32'd1);
    check("rst_irdy", 32'(bus.irdy), 32'd1);
    check("rst_oe", 32'(bus.oe), 32'd0);
    check("rst_ad", bus.ad, 32'd0);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write
    bus.gnt = 1'b0;
    push(32'hA5A5_0001);
    #1 check("single_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd(32'h100, 4'd1, 0, 1'b0);
    check("single_done", 32'(n_done), 32'd1);
    check("single_err", 32'(n_errp), 32'd0);
    check("single_req_cycles", 32'(n_req), 32'd1);
    check("single_addr_n", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() > 0) check("single_addr", got_addr[0], 32'h100);
    check("single_data_n", 32'(got_data.size()), 32'd1);
    if (got_data.size() > 0) begin
      check("single_data", got_data[0], 32'hA5A5_0001);
      check("single_frame", 32'(got_frame[0]), 32'd1);
    end

    // Burst with alternating target waits
    for (int i = 0; i < 4; i++) push(32'h1111_0000 + 32'(i));
    run_cmd(32'h200, 4'd4, 1, 1'b0);
    check("burst_done", 32'(n_done), 32'd1);
    check("burst_addr_n", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() > 0) check("burst_addr", got_addr[0], 32'h200);
    check("burst_waits", 32'(n_wait), 32'd3);
    check("burst_data_n", 32'(got_data.size()), 32'd4);
    for (int i = 0; i < got_data.size(); i++) begin
      check("burst_data", got_data[i], 32'h1111_0000 + 32'(i));
      check("burst_frame", 32'(got_frame[i]), (i == 3) ? 32'd1 : 32'd0);
    end

    // Grant lost at first completion
    for (int i = 0; i < 4; i++) push(32'h2222_0000 + 32'(i));
    run_cmd(32'h300, 4'd4, 0, 1'b1);
    check("gloss_done", 32'(n_done), 32'd1);
    check("gloss_addr_n", 32'(got_addr.size()), 32'd2);
    if (got_addr.size() > 1) begin
      check("gloss_addr0", got_addr[0], 32'h300);
      check("gloss_addr1", got_addr[1], 32'h308);
    end
    check("gloss_data_n", 32'(got_data.size()), 32'd4);
    for (int i = 0; i < got_data.size(); i++) begin
      check("gloss_data", got_data[i], 32'h2222_0000 + 32'(i));
      check("gloss_frame", 32'(got_frame[i]), (i == 1 || i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("gloss_no_2nd_done", 32'(done), 32'd0);

    // Master abort
    push(32'h3333_0000);
    push(32'h3333_0001);
    run_cmd(32'h400, 4'd2, 2, 1'b0);
    check("abort_err", 32'(n_errp), 32'd1);
    check("abort_done", 32'(n_done), 32'd0);
    check("abort_data_n", 32'(got_data.size()), 32'd0);
    check("abort_waits", 32'(n_wait), 32'd16);
    check("abort_released", 32'(rel_ok), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    cmd_len = 4'd1;
    #1 check("abort_fifo_empty", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("abort_err_pulse", 32'(err), 32'd0);

    // Zero-length command
    cmd_len = 4'd0;
    #1 check("len0_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd(32'h500, 4'd0, 0, 1'b0);
    check("len0_done", 32'(n_done), 32'd1);
    check("len0_req", 32'(n_req), 32'd0);
    check("len0_addr_n", 32'(got_addr.size()), 32'd0);

    // Overflow: ninth push dropped
    for (int i = 0; i < 9; i++) push(32'h4444_0000 + 32'(i));
    check("full_wready", 32'(wready), 32'd0);
    cmd_len = 4'd8;
    #1 check("full_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd(32'h600, 4'd8, 0, 1'b0);
    check("full_data_n", 32'(got_data.size()), 32'd8);
    for (int i = 0; i < got_data.size(); i++)
      check("full_data", got_data[i], 32'h4444_0000 + 32'(i));
    check("full_drain_wready", 32'(wready), 32'd1);
    cmd_len = 4'd1;
    #1 check("full_drain_empty", 32'(cmd_ready), 32'd0);

    // Reset in the middle of a burst
    push(32'h5555_0000);
    push(32'h5555_0001);
    bus.trdy  = 1'b1;
    cmd_addr  = 32'h700;
    cmd_len   = 4'd2;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_oe_before_rst", 32'(bus.oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_bus", 32'({bus.req, bus.frame, bus.irdy, bus.oe}), 32'hE);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cmd_len = 4'd1;
    #1 check("mid_rst_fifo_empty", 32'(cmd_ready), 32'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
